alu_seq_unit: RTL and testbench

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_types_pkg.sv | 47 ++++
 rtl/alu_shift_step.sv | 36 +++
 rtl/alu_seq_unit.sv | 133 +++++++++++++
 tb/tb_alu_seq_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_types_pkg.sv
// Shared types for the sequential ALU: operation encodings, FSM states and the
// single-cycle (non-shift) result function.
package alu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_seq_state_t;

    function automatic logic is_shift(input aluop_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    // Shift encodings and the unused 4'b1010-4'b1111 range fall to zero here.
    function automatic logic [31:0] alu_compute(input aluop_t op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Shift datapath: one bit position per call by default, or a full barrel
// shifter when ALU_FAST_SHIFT_EN is defined.
module alu_shift_step
    import alu_types_pkg::*;
(
    input  logic [31:0] data,
    input  aluop_t      op,
`ifdef ALU_FAST_SHIFT_EN
    input  logic [4:0]  amount,
`endif
    output logic [31:0] result
);

`ifdef ALU_FAST_SHIFT_EN
    always_comb begin
        result = data;
        case (op)
            ALU_SLL: result = data << amount;
            ALU_SRL: result = data >> amount;
            ALU_SRA: result = $unsigned($signed(data) >>> amount);
            default: result = data;
        endcase
    end
`else
    always_comb begin
        result = data;
        case (op)
            ALU_SLL: result = {data[30:0], 1'b0};
            ALU_SRL: result = {1'b0, data[31:1]};
            ALU_SRA: result = {data[31], data[31:1]};
            default: result = data;
        endcase
    end
`endif

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU with valid/ready handshakes. Shifts iterate one bit per cycle
// unless ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_seq_unit
    import alu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  aluop_t      aluop,
    input  logic [31:0] port_a,
    input  logic [31:0] port_b,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] port_out,
    output logic        zero
);

    alu_seq_state_t state, next_state;
    logic           accept;
    logic           start_iter;
    logic [4:0]     shift_amt;
    logic [31:0]    step_out;
    logic [31:0]    single_result;

    assign shift_amt  = port_b[4:0];
    assign req_ready  = (state == IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == DONE);
    assign zero       = (port_out == 32'd0);

`ifdef ALU_FAST_SHIFT_EN
    alu_shift_step u_shift (
        .data   (port_a),
        .op     (aluop),
        .amount (shift_amt),
        .result (step_out)
    );

    assign start_iter    = 1'b0;
    assign single_result = is_shift(aluop) ? step_out : alu_compute(aluop, port_a, port_b);
`else
    logic [31:0] work;
    aluop_t      shift_op;
    logic [4:0]  shift_cnt;

    alu_shift_step u_shift (
        .data   (work),
        .op     (shift_op),
        .result (step_out)
    );

    assign start_iter    = accept && is_shift(aluop) && (shift_amt != 5'd0);
    // A zero-amount shift passes operand A straight through.
    assign single_result = is_shift(aluop) ? port_a : alu_compute(aluop, port_a, port_b);
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = start_iter ? SHIFT : DONE;
                end
            end
            SHIFT: begin
`ifdef ALU_FAST_SHIFT_EN
                next_state = IDLE;
`else
                if (shift_cnt == 5'd1) begin
                    next_state = DONE;
                end
`endif
            end
            DONE: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

`ifdef ALU_FAST_SHIFT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            port_out <= '0;
        end else if (accept) begin
            port_out <= single_result;
        end
    end
`else
    // The shift works in a private register so port_out keeps the previous
    // result until the new one is complete.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            port_out  <= '0;
            work      <= '0;
            shift_op  <= ALU_ADD;
            shift_cnt <= '0;
        end else if (flush) begin
            shift_cnt <= '0;
        end else if (accept) begin
            if (start_iter) begin
                work      <= port_a;
                shift_op  <= aluop;
                shift_cnt <= shift_amt;
            end else begin
                port_out  <= single_result;
            end
        end else if (state == SHIFT) begin
            work      <= step_out;
            shift_cnt <= shift_cnt - 5'd1;
            if (shift_cnt == 5'd1) begin
                port_out <= step_out;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed, table-driven bench for alu_seq_unit with hand-written sequences
// for back-pressure, flush and mid-shift reset.
module tb_alu_seq_unit;
    import alu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        req_valid;
    logic        req_ready;
    aluop_t      aluop;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] port_out;
    logic        zero;

    int passCount;
    int checkCount;

    typedef struct {
        aluop_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[15];

    alu_seq_unit dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .aluop      (aluop),
        .port_a     (port_a),
        .port_b     (port_b),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .port_out   (port_out),
        .zero       (zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int expLatency(input aluop_t op, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        if (is_shift(op) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    // Presents one request at a falling edge and returns the number of cycles
    // until resp_valid is observed (41 if it never appears).
    task automatic applyStimulus(input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                                 output int lat);
        aluop     = op;
        port_a    = a;
        port_b    = b;
        req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat <= 40) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic seen;

        vecs[0]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[1]  = '{ALU_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
        vecs[2]  = '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[3]  = '{ALU_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
        vecs[4]  = '{ALU_XOR,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555};
        vecs[5]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[6]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[7]  = '{ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
        vecs[8]  = '{ALU_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[9]  = '{ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        vecs[10] = '{ALU_SLL,  32'h0000_0001, 32'h0000_0025, 32'h0000_0020};
        vecs[11] = '{ALU_SRA,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
        vecs[12] = '{aluop_t'(4'hA), 32'h0000_0001, 32'h0000_0002, 32'h0000_0000};
        vecs[13] = '{ALU_SRA,  32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000};
        vecs[14] = '{ALU_SRL,  32'h8000_0001, 32'h0000_0001, 32'h4000_0000};

        passCount  = 0;
        checkCount = 0;
        nRST       = 1'b0;
        req_valid  = 1'b0;
        aluop      = ALU_ADD;
        port_a     = '0;
        port_b     = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;

        #1;
        checkOutput("reset_port_out",   port_out, 32'd0);
        checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset_zero",       {31'd0, zero}, 32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        checkOutput("idle_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, expLatency(vecs[i].op, vecs[i].b));
            checkOutput($sformatf("vec%0d_result", i), port_out, vecs[i].res);
            checkOutput($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].res == 32'd0});
            @(negedge CLK);
            checkOutput($sformatf("vec%0d_released", i), {31'd0, resp_valid}, 32'd0);
            checkOutput($sformatf("vec%0d_retained", i), port_out, vecs[i].res);
        end

        // Consumer stalls for three cycles: the response must sit unchanged.
        resp_ready = 1'b0;
        applyStimulus(ALU_SLL, 32'h0000_0001, 32'h0000_0025, lat);
        checkOutput("stall_latency", lat, expLatency(ALU_SLL, 32'h25));
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checkOutput("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("stall_port_out",   port_out, 32'h0000_0020);
            checkOutput("stall_req_ready",  {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge CLK);
        checkOutput("stall_release_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("stall_release_ready", {31'd0, req_ready}, 32'd1);

`ifndef ALU_FAST_SHIFT_EN
        // Flush two cycles into a 31-bit SRL: no response, old result kept.
        aluop     = ALU_SRL;
        port_a    = 32'hFFFF_FFFF;
        port_b    = 32'd31;
        req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        flush = 1'b1;
        #1;
        checkOutput("flush_req_ready_low", {31'd0, req_ready}, 32'd0);
        @(negedge CLK);
        flush = 1'b0;
        #1;
        checkOutput("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("flush_req_ready",  {31'd0, req_ready}, 32'd1);
        checkOutput("flush_port_out",   port_out, 32'h0000_0020);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (resp_valid) seen = 1'b1;
        end
        checkOutput("flush_no_response", {31'd0, seen}, 32'd0);

        // A request held together with flush must be ignored.
        flush     = 1'b1;
        aluop     = ALU_ADD;
        port_a    = 32'd7;
        port_b    = 32'd8;
        req_valid = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge CLK);
        checkOutput("flush_req_ignored",  {31'd0, resp_valid}, 32'd0);
        checkOutput("flush_req_port_out", port_out, 32'h0000_0020);

        // Reset in the middle of a shift discards it immediately.
        aluop     = ALU_SLL;
        port_a    = 32'd3;
        port_b    = 32'd10;
        req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        checkOutput("midreset_port_out",   port_out, 32'd0);
        checkOutput("midreset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("midreset_zero",       {31'd0, zero}, 32'd1);
        checkOutput("midreset_req_ready",  {31'd0, req_ready}, 32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            if (resp_valid) seen = 1'b1;
        end
        checkOutput("midreset_no_response", {31'd0, seen}, 32'd0);
`endif

        applyStimulus(ALU_ADD, 32'd2, 32'd3, lat);
        checkOutput("post_reset_add_latency", lat, 1);
        checkOutput("post_reset_add_result",  port_out, 32'd5);
        @(negedge CLK);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
